// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised CPU register file with a program-counter slot,
// two prioritised write ports (A = ALU result, B = load return) and a
// load-use scoreboard that flags a hazard when a read operand waits on an
// outstanding load.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data onto
// the read ports and pc_out, and to mask the hazard for a load returning in
// the current cycle.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_IDX   = 15,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       addr_rn,
  input  logic [AW-1:0]       addr_rs,
  input  logic [AW-1:0]       addr_rm,
  input  logic [AW-1:0]       addr_rd,
  input  logic                use_rn,
  input  logic                use_rs,
  input  logic                use_rm,
  input  logic                use_rd,
  output logic [DATA_W-1:0]   rn,
  output logic [DATA_W-1:0]   rs,
  output logic [DATA_W-1:0]   rm,
  output logic [DATA_W-1:0]   rd,
  input  logic [DATA_W-1:0]   pc_next,
  output logic [DATA_W-1:0]   pc_out,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [DATA_W-1:0]   wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ld_issue,
  input  logic [AW-1:0]       ld_addr,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy
);

  logic signed [DATA_W-1:0] regs_p0 [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_p0;

  // Operand views: index 0..3 = rn, rs, rm, rd
  logic [AW-1:0]     op_addr [4];
  logic [3:0]        op_use;
  logic [3:0]        op_wait;
  logic [DATA_W-1:0] op_data [4];

  assign op_addr = '{addr_rn, addr_rs, addr_rm, addr_rd};
  assign op_use  = {use_rd, use_rm, use_rs, use_rn};

  // ---- state update: array writes (A over B over pc_next) and scoreboard ----
  // Architectural state and scoreboard update; port A wins since it carries the younger result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_p0[i] <= (i == PC_IDX) ? RESET_PC : '0;
      end
      busy_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wa_en && wa_addr == AW'(i)) begin
          regs_p0[i] <= wa_data;
        end else if (wb_en && wb_addr == AW'(i)) begin
          regs_p0[i] <= wb_data;
        end else if (i == PC_IDX) begin
          regs_p0[i] <= pc_next;
        end
      end
      // A new load to the same destination keeps the register busy even
      // when an older load to it returns this cycle.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_issue && ld_addr == AW'(i)) begin
          busy_p0[i] <= 1'b1;
        end else if (wb_en && wb_addr == AW'(i)) begin
          busy_p0[i] <= 1'b0;
        end
      end
    end
  end

  // ---- combinational read side (no latency) ----
  // Read ports: stored value, optionally overridden by same-cycle writes.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      op_data[k] = regs_p0[op_addr[k]];
`ifdef RF_BYPASS_EN
      if (wb_en && wb_addr == op_addr[k]) op_data[k] = wb_data;
      if (wa_en && wa_addr == op_addr[k]) op_data[k] = wa_data;
`endif
    end
  end

  assign rn = op_data[0];
  assign rs = op_data[1];
  assign rm = op_data[2];
  assign rd = op_data[3];

  // PC output: forwards explicit writes to the PC slot but never pc_next.
  always_comb begin
    pc_out = regs_p0[PC_IDX];
`ifdef RF_BYPASS_EN
    if (wb_en && wb_addr == AW'(PC_IDX)) pc_out = wb_data;
    if (wa_en && wa_addr == AW'(PC_IDX)) pc_out = wa_data;
`endif
  end

  // Per-operand load-use wait; a load returning now unblocks its consumer under bypass.
  always_comb begin
    op_wait = '0;
    for (int k = 0; k < 4; k++) begin
      op_wait[k] = op_use[k] && busy_p0[op_addr[k]];
`ifdef RF_BYPASS_EN
      if (wb_en && wb_addr == op_addr[k] && !(ld_issue && ld_addr == op_addr[k])) begin
        op_wait[k] = 1'b0;
      end
`endif
    end
  end

  assign hazard = |op_wait;
  assign busy   = busy_p0;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, a same-cycle forwarding
// sequence, and randomized traffic compared against a behavioural model.
module tb_reg_file_sb;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk;
  logic        rst;
  logic [3:0]  addr_rn, addr_rs, addr_rm, addr_rd;
  logic        use_rn, use_rs, use_rm, use_rd;
  logic [31:0] rn, rs, rm, rd;
  logic [31:0] pc_next, pc_out;
  logic        wa_en, wb_en, ld_issue;
  logic [3:0]  wa_addr, wb_addr, ld_addr;
  logic [31:0] wa_data, wb_data;
  logic        hazard;
  logic [15:0] busy;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_mem [16];
  logic [15:0] m_busy;

  reg_file_sb #(.DATA_W(32), .NUM_REGS(16), .PC_IDX(15), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .addr_rn(addr_rn), .addr_rs(addr_rs), .addr_rm(addr_rm), .addr_rd(addr_rd),
    .use_rn(use_rn), .use_rs(use_rs), .use_rm(use_rm), .use_rd(use_rd),
    .rn(rn), .rs(rs), .rm(rm), .rd(rd),
    .pc_next(pc_next), .pc_out(pc_out),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr),
    .hazard(hazard), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wa_en;  logic [3:0] wa_addr; logic [31:0] wa_data;
    logic        wb_en;  logic [3:0] wb_addr; logic [31:0] wb_data;
    logic        ld;     logic [3:0] ld_addr;
    logic [31:0] pc_next;
    logic [3:0]  a_rn;   logic [3:0] a_rm;    logic use_rm;
    logic [31:0] e_pc;   logic [31:0] e_rn;   logic [31:0] e_rm;
    logic        e_hz;   logic [15:0] e_busy;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_writes();
    rst = 1'b0; wa_en = 1'b0; wb_en = 1'b0; ld_issue = 1'b0;
  endtask

  // Advance one clock and apply the architectural rules to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_mem[15] = RST_PC;
      m_busy = 16'h0;
    end else begin
      m_mem[15] = pc_next;
      if (wb_en) m_mem[wb_addr] = wb_data;
      if (wa_en) m_mem[wa_addr] = wa_data;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (ld_issue) m_busy[ld_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] v;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (wb_en && wb_addr == a) v = wb_data;
    if (wa_en && wa_addr == a) v = wa_data;
`endif
    return v;
  endfunction

  function automatic logic m_wait(input logic u, input logic [3:0] a);
    logic w;
    w = u && m_busy[a];
`ifdef RF_BYPASS_EN
    if (wb_en && wb_addr == a && !(ld_issue && ld_addr == a)) w = 1'b0;
`endif
    return w;
  endfunction

  function automatic logic [3:0] raddr();
    if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    // rst wa_en wa_a wa_d  wb_en wb_a wb_d  ld ld_a  pc_next  rn rm use_rm  e_pc e_rn e_rm e_hz e_busy
    vt[0] = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
              4'd3, 4'd0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 4'd5, 32'hAAAA, 1'b1, 4'd5, 32'h5555, 1'b0, 4'd0, 32'h100,
              4'd5, 4'd0, 1'b0, 32'h100, 32'hAAAA, 32'h0, 1'b0, 16'h0000};
    vt[2] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 32'h100,
              4'd5, 4'd0, 1'b0, 32'h100, 32'h1234, 32'h0, 1'b0, 16'h0000};
    vt[3] = '{1'b0, 1'b1, 4'd15, 32'h200, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h104,
              4'd5, 4'd0, 1'b0, 32'h200, 32'h1234, 32'h0, 1'b0, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h204,
              4'd5, 4'd0, 1'b0, 32'h204, 32'h1234, 32'h0, 1'b0, 16'h0000};
    vt[5] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h204,
              4'd5, 4'd2, 1'b1, 32'h204, 32'h1234, 32'h0, 1'b1, 16'h0004};
    vt[6] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h204,
              4'd5, 4'd2, 1'b0, 32'h204, 32'h1234, 32'h0, 1'b0, 16'h0004};
    vt[7] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'hBEEF, 1'b0, 4'd0, 32'h204,
              4'd5, 4'd2, 1'b1, 32'h204, 32'h1234, 32'hBEEF, 1'b0, 16'h0000};
    vt[8] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h7777, 1'b1, 4'd7, 32'h204,
              4'd7, 4'd2, 1'b0, 32'h204, 32'h7777, 32'hBEEF, 1'b0, 16'h0080};
    vt[9] = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h204,
              4'd7, 4'd2, 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 16'h0000};

    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_busy = 16'h0;
    idle_writes();
    rst = 1'b1;
    addr_rn = 4'd0; addr_rs = 4'd0; addr_rm = 4'd0; addr_rd = 4'd0;
    use_rn = 1'b0; use_rs = 1'b0; use_rm = 1'b0; use_rd = 1'b0;
    wa_addr = 4'd0; wb_addr = 4'd0; ld_addr = 4'd0;
    wa_data = 32'h0; wb_data = 32'h0; pc_next = 32'h0;
    tick();
    #1;

    // Directed table: apply one cycle of inputs, check the following cycle
    for (int v = 0; v < 10; v++) begin
      rst = vt[v].rst;
      wa_en = vt[v].wa_en; wa_addr = vt[v].wa_addr; wa_data = vt[v].wa_data;
      wb_en = vt[v].wb_en; wb_addr = vt[v].wb_addr; wb_data = vt[v].wb_data;
      ld_issue = vt[v].ld; ld_addr = vt[v].ld_addr;
      pc_next = vt[v].pc_next;
      addr_rn = vt[v].a_rn; addr_rm = vt[v].a_rm; use_rm = vt[v].use_rm;
      tick();
      #1;
      idle_writes();
      #1;
      chk($sformatf("vec%0d pc_out", v), pc_out, vt[v].e_pc);
      chk($sformatf("vec%0d rn", v), rn, vt[v].e_rn);
      chk($sformatf("vec%0d rm", v), rm, vt[v].e_rm);
      chk($sformatf("vec%0d hazard", v), 32'(hazard), 32'(vt[v].e_hz));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'(vt[v].e_busy));
    end

    // Same-cycle write visibility and load-return hazard
    use_rm = 1'b0;
    pc_next = 32'h100;
    wa_en = 1'b1; wa_addr = 4'd4; wa_data = 32'h11;
    tick(); #1; idle_writes();
    ld_issue = 1'b1; ld_addr = 4'd6;
    tick(); #1; idle_writes();
    wa_en = 1'b1; wa_addr = 4'd4; wa_data = 32'h77;
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
    addr_rn = 4'd4; addr_rs = 4'd6; use_rs = 1'b1;
    #3;
`ifdef RF_BYPASS_EN
    chk("byp rn same cycle", rn, 32'h77);
    chk("byp rs same cycle", rs, 32'h66);
    chk("byp hazard same cycle", 32'(hazard), 32'h0);
`else
    chk("nobyp rn same cycle", rn, 32'h11);
    chk("nobyp rs same cycle", rs, 32'h0);
    chk("nobyp hazard same cycle", 32'(hazard), 32'h1);
`endif
    tick(); #1; idle_writes(); #1;
    chk("seq rn next cycle", rn, 32'h77);
    chk("seq rs next cycle", rs, 32'h66);
    chk("seq hazard next cycle", 32'(hazard), 32'h0);
    chk("seq busy next cycle", 32'(busy), 32'h0);
    use_rs = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 31) == 0);
      wa_en = 1'($urandom_range(0, 1)); wa_addr = raddr(); wa_data = $urandom();
      wb_en = 1'($urandom_range(0, 1)); wb_addr = raddr(); wb_data = $urandom();
      ld_issue = 1'($urandom_range(0, 1)); ld_addr = raddr();
      pc_next = $urandom();
      addr_rn = raddr(); addr_rs = raddr(); addr_rm = raddr(); addr_rd = raddr();
      use_rn = 1'($urandom_range(0, 1)); use_rs = 1'($urandom_range(0, 1));
      use_rm = 1'($urandom_range(0, 1)); use_rd = 1'($urandom_range(0, 1));
      #3;
      chk($sformatf("rand%0d rn", c), rn, m_read(addr_rn));
      chk($sformatf("rand%0d rs", c), rs, m_read(addr_rs));
      chk($sformatf("rand%0d rm", c), rm, m_read(addr_rm));
      chk($sformatf("rand%0d rd", c), rd, m_read(addr_rd));
      chk($sformatf("rand%0d pc_out", c), pc_out, m_read(4'd15));
      chk($sformatf("rand%0d busy", c), 32'(busy), 32'(m_busy));
      chk($sformatf("rand%0d hazard", c), 32'(hazard),
          32'(m_wait(use_rn, addr_rn) | m_wait(use_rs, addr_rs) |
              m_wait(use_rm, addr_rm) | m_wait(use_rd, addr_rd)));
      tick();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the CPU register file.
- Adds a synchronous reset, two write ports (ALU result and DMEM load return) with fixed priority, and a load-use scoreboard that raises a hazard.
- PC register handling is retained.
- Sits between the decoder/control (read addresses, write enables, load issue) and the datapath (ALU, DMEM, PC logic).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers; power of two, at least 4.
- PC_IDX, 15, index of the register that holds the program counter.
- RESET_PC, 0, value loaded into r[PC_IDX] on reset.
- AW (local), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- addr_rn, addr_rs, addr_rm, addr_rd  in  AW each  read addresses.
- use_rn, use_rs, use_rm, use_rd  in  1 each  the instruction actually reads that operand (hazard qualifier).
- rn, rs, rm, rd  out  DATA_W each  read data.
- pc_next  in  DATA_W  next PC value.
- pc_out  out  DATA_W  current r[PC_IDX].
- wa_en  in  1, wa_addr  in  AW, wa_data  in  DATA_W  write port A (ALU).
- wb_en  in  1, wb_addr  in  AW, wb_data  in  DATA_W  write port B (load return).
- ld_issue  in  1, ld_addr  in  AW  load issued to DMEM; ld_addr is its destination.
- hazard  out  1  a read operand is waiting on an outstanding load.
- busy  out  NUM_REGS  scoreboard bit per register.

Behaviour:
- Reset, on a clk edge with rst=1:
  - r[PC_IDX] <= RESET_PC; all other r[i] <= 0; busy <= 0.
  - All write ports, ld_issue and pc_next are ignored that cycle.
- Outputs after reset:
  - pc_out = RESET_PC; busy = 0; hazard = 0.
  - rn/rs/rm/rd = 0 unless the address is PC_IDX.
  - The BYPASS_EN path can override these while a write is presented.
- Reads are combinational from the array: rx = r[addr_x]. There is no read latency.
- Normal write cycle (rst=0), per register i, highest priority first:
  - wa_en && wa_addr==i -> wa_data.
  - wb_en && wb_addr==i -> wb_data.
  - i==PC_IDX -> pc_next.
  - Otherwise hold.
- Port A beats port B on an address collision because the ALU result belongs to the younger instruction.
- A branch implemented as a write to PC_IDX overrides pc_next.
- Latency: a write presented in cycle N is visible on the read ports in cycle N+1 (without BYPASS_EN).
- Scoreboard, for each i:
  - Set when ld_issue && ld_addr==i.
  - Else cleared when wb_en && wb_addr==i.
  - Set wins over clear in the same cycle (a back-to-back load to the same destination stays busy).
  - wa_en does not touch busy.
  - wb_en to a register whose busy bit is clear still writes.
  - ld_issue to PC_IDX is permitted and sets busy[PC_IDX].
- hazard is combinational and registered nowhere:
  - hazard = OR over x in {rn,rs,rm,rd} of (use_x && busy[addr_x]).
  - It uses current-cycle busy, so a clear in this cycle is seen next cycle unless BYPASS_EN is defined.
- Reset mid-operation:
  - All outstanding busy bits are dropped.
  - A late wb_en after reset is a plain write; the block does not suppress it.
- Addresses are exactly AW bits, so there is no out-of-range case.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data, with the same priority as the array: wa (address match, wa_en) over wb over the stored value.
  - Writes to PC_IDX are forwarded too; pc_out forwards wa/wb writes to PC_IDX but not pc_next.
  - The hazard term for an operand is masked when wb_en && wb_addr==addr_x && !(ld_issue && ld_addr==addr_x).
  - Net effect: a load returning this cycle does not stall its consumer.
- Undefined: reads and hazard come purely from the stored state, as described above.

Test Plan:
- Reset with rst=1, RESET_PC=0x100 -> next cycle pc_out=0x100, rn(addr 3)=0, busy=0, hazard=0.
- wa_en=1, wb_en=1, both to addr 5 with wa_data=0xAAAA and wb_data=0x5555 -> next cycle rn(addr 5)=0xAAAA. Then wb alone to addr 5 with 0x1234 -> next cycle 0x1234.
- pc_next=0x104 with wa_en to PC_IDX carrying 0x200 -> next cycle pc_out=0x200. Following cycle with pc_next=0x204 and no write -> pc_out=0x204.
- ld_issue with ld_addr=2, then addr_rm=2 with use_rm=1 -> hazard=1. With use_rm=0 -> hazard=0. wb_en to addr 2 with 0xBEEF -> next cycle busy[2]=0, hazard=0, rm=0xBEEF.
- ld_issue and wb_en both to addr 7 in the same cycle -> busy[7] stays 1 and r[7]=wb_data. rst=1 while busy[7]=1 -> busy=0 next cycle.
- With RF_BYPASS_EN: wa_en to addr 4 with 0x77 and addr_rn=4 in the same cycle -> rn=0x77 immediately. wb to busy reg 6 with addr_rs=6, use_rs=1 -> hazard=0 that cycle. Without the macro: rn=old value and hazard=1 in that cycle.
